rca_pipe: RTL

//   Parametrised, pipelined ripple-carry adder/subtractor. WIDTH-bit operands are split

---
 rtl/rca_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rca_pipe.sv
// rca_pipe: pipelined ripple-carry adder/subtractor.
// The operands are cut into NSEG segments of SEG bits. Stage k adds segment k
// using the carry registered by stage k-1. Operand bits that are not yet
// consumed shrink by one segment per stage, and the finished low result bits
// grow by one segment per stage. Every stage moves only when the output
// register is empty or is being drained.
module rca_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;

  if (SEG < 1 || WIDTH % SEG != 0) begin : g_bad_cfg
    $error("rca_pipe: WIDTH must be a non-zero multiple of SEG");
  end

  // One SEG-bit ripple chain: returns {carry_out, sum_bits}.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic           c;
    logic [SEG-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < SEG; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Whole pipe advances unless a finished result is waiting on the consumer.
  always_comb begin
    en       = !out_valid || out_ready;
    in_ready = en;
  end

  // Subtraction is a + ~b + ~cin; fold the mode into operand B and carry-in.
  always_comb begin
    b_eff = sub ? ~b : b;
    c0    = sub ? ~cin : cin;
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int RW = (k + 1) * SEG;     // result bits known after this stage
    localparam int IW = WIDTH - k * SEG;   // operand bits entering this stage

    logic [IW-1:0]  src_a, src_b;
    logic           src_c, src_v;
    logic [SEG:0]   add;
    logic [RW-1:0]  r_in;
    logic           v_d, v_q, c_d, c_q;
    logic [RW-1:0]  r_d, r_q;

    if (k == 0) begin : g_src
      assign src_a = a;
      assign src_b = b_eff;
      assign src_c = c0;
      assign src_v = in_valid;
      assign r_in  = add[SEG-1:0];
    end else begin : g_src
      assign src_a = g_stg[k-1].g_op.a_q;
      assign src_b = g_stg[k-1].g_op.b_q;
      assign src_c = g_stg[k-1].c_q;
      assign src_v = g_stg[k-1].v_q;
      assign r_in  = {add[SEG-1:0], g_stg[k-1].r_q};
    end

    assign add = seg_add(src_a[SEG-1:0], src_b[SEG-1:0], src_c);

    // Stage valid, carry and accumulated result load when the pipe moves.
    always_comb begin
      v_d = v_q;
      c_d = c_q;
      r_d = r_q;
      if (en) begin
        v_d = src_v;
        c_d = add[SEG];
        r_d = r_in;
      end
    end

    // Stage state register; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        r_q <= r_d;
      end
    end

    if (k < NSEG - 1) begin : g_op
      logic [IW-SEG-1:0] a_d, a_q, b_d, b_q;

      // Carry the not-yet-added operand bits forward, dropping this segment.
      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (en) begin
          a_d = src_a[IW-1:SEG];
          b_d = src_b[IW-1:SEG];
        end
      end

      // Remaining-operand register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == NSEG - 1) begin : g_ovf
      logic c_msb, ovf_d, ovf_q;

      // Carry into the MSB is recovered from the MSB sum bit and its inputs.
      always_comb begin
        c_msb = src_a[SEG-1] ^ src_b[SEG-1] ^ add[SEG-1];
        ovf_d = en ? (c_msb ^ add[SEG]) : ovf_q;
      end

      // Signed overflow flag, aligned with the final stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = g_stg[NSEG-1].v_q;
  assign sum       = g_stg[NSEG-1].r_q;
  assign cout      = g_stg[NSEG-1].c_q;
  assign ovf       = g_stg[NSEG-1].g_ovf.ovf_q;

endmodule
